// File: rtl/conv_pu_stream.sv
// Streaming KxK convolution unit: raster pixels in, one windowed dot product (+bias, optional ReLU) out.
// Latency 2 cycles from the accepting edge of a window-completing pixel; any stalled output freezes the whole pipe.
module conv_pu_stream #(
    parameter int K      = 3,
    parameter int IMG_W  = 5,
    parameter int DATA_W = 8,
    parameter int WGT_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wgt_valid,
    input  logic [WGT_W-1:0]  wgt_data,
    output logic              wgt_ready,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    input  logic              relu_en,
    input  logic              stride_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam int NW = K * K;
    localparam int IW = $clog2(NW);
    localparam int CW = $clog2(IMG_W);
    localparam int PW = DATA_W + 1 + WGT_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    state_q, state_d;
    logic signed [WGT_W-1:0]   w_q [NW];
    logic signed [WGT_W-1:0]   w_d [NW];
    logic [IW-1:0]             wgt_idx_q, wgt_idx_d;
    logic                      wgts_loaded_q, wgts_loaded_d;
    logic [ACC_W-1:0]          bias_q, bias_d;
    logic                      relu_q, relu_d, stride_q, stride_d;
    logic [CW-1:0]             row_q, row_d, col_q, col_d;
    logic [DATA_W-1:0]         lb_q  [K-1][IMG_W];
    logic [DATA_W-1:0]         lb_d  [K-1][IMG_W];
    logic [DATA_W-1:0]         win_q [K][K];
    logic [DATA_W-1:0]         win_d [K][K];
    logic                      win_vld_q, win_vld_d, win_last_q, win_last_d;
    logic signed [PW-1:0]      prod_q [NW];
    logic signed [PW-1:0]      prod_d [NW];
    logic                      s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [ACC_W-1:0]          out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;

    logic                      stall, accept, drained, win_ok, win_final;
    logic [CW-1:0]             row_rel, col_rel;
    logic signed [ACC_W-1:0]   sum;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = (state_q == S_RUN) && !stall;
    assign accept    = in_valid && in_ready;
    assign wgt_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign drained   = !win_vld_q && !s1_vld_q && !out_valid_q;
    assign done      = (state_q == S_DRAIN) && drained && !clear;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Window position is judged on the counters of the pixel being accepted.
    assign row_rel   = row_q - CW'(K - 1);
    assign col_rel   = col_q - CW'(K - 1);
    assign win_ok    = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1)) &&
                       (!stride_q || (!row_rel[0] && !col_rel[0]));
    assign win_final = (int'(row_q) >= IMG_W - (stride_q ? 2 : 1)) &&
                       (int'(col_q) >= IMG_W - (stride_q ? 2 : 1));

    always_comb begin
        sum = bias_q;
        for (int i = 0; i < NW; i++) begin
            sum = sum + ACC_W'(prod_q[i]);
        end
        if (relu_q && sum[ACC_W-1]) begin
            sum = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        wgt_idx_d     = wgt_idx_q;
        wgts_loaded_d = wgts_loaded_q;
        bias_d        = bias_q;
        relu_d        = relu_q;
        stride_d      = stride_q;
        row_d         = row_q;
        col_d         = col_q;
        lb_d          = lb_q;
        win_d         = win_q;
        win_vld_d     = win_vld_q;
        win_last_d    = win_last_q;
        prod_d        = prod_q;
        s1_vld_d      = s1_vld_q;
        s1_last_d     = s1_last_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;

        if (state_q == S_IDLE && wgt_valid) begin
            w_d[wgt_idx_q] = wgt_data;
            if (wgt_idx_q == IW'(NW - 1)) begin
                wgt_idx_d     = '0;
                wgts_loaded_d = 1'b1;
            end else begin
                wgt_idx_d = wgt_idx_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && wgts_loaded_q) begin
                    state_d  = S_RUN;
                    bias_d   = bias;
                    relu_d   = relu_en;
                    stride_d = stride_sel;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            S_RUN: begin
                if (accept && row_q == CW'(IMG_W - 1) && col_q == CW'(IMG_W - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Row r of the window is fed by the delay line that is (K-1-r) image rows old.
        if (accept) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int i = IMG_W - 1; i > 0; i--) begin
                    lb_d[j][i] = lb_q[j][i-1];
                end
                lb_d[j][0] = (j == 0) ? in_data : lb_q[(j == 0) ? 0 : j - 1][IMG_W-1];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = (r == K - 1) ? in_data : lb_q[(r == K - 1) ? 0 : K - 2 - r][IMG_W-1];
            end
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(IMG_W - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (!stall) begin
            win_vld_d  = accept && win_ok;
            win_last_d = accept && win_ok && win_final;
            for (int i = 0; i < NW; i++) begin
                prod_d[i] = PW'($signed({1'b0, win_q[i/K][i%K]})) * PW'(w_q[i]);
            end
            s1_vld_d    = win_vld_q;
            s1_last_d   = win_last_q;
            out_valid_d = s1_vld_q;
            out_last_d  = s1_last_q;
            if (s1_vld_q) begin
                out_data_d = sum;
            end
        end

        if (clear) begin
            state_d     = S_IDLE;
            row_d       = '0;
            col_d       = '0;
            win_vld_d   = 1'b0;
            win_last_d  = 1'b0;
            s1_vld_d    = 1'b0;
            s1_last_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            w_q           <= '{default: '0};
            wgt_idx_q     <= '0;
            wgts_loaded_q <= 1'b0;
            bias_q        <= '0;
            relu_q        <= 1'b0;
            stride_q      <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            lb_q          <= '{default: '{default: '0}};
            win_q         <= '{default: '{default: '0}};
            win_vld_q     <= 1'b0;
            win_last_q    <= 1'b0;
            prod_q        <= '{default: '0};
            s1_vld_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            wgt_idx_q     <= wgt_idx_d;
            wgts_loaded_q <= wgts_loaded_d;
            bias_q        <= bias_d;
            relu_q        <= relu_d;
            stride_q      <= stride_d;
            row_q         <= row_d;
            col_q         <= col_d;
            lb_q          <= lb_d;
            win_q         <= win_d;
            win_vld_q     <= win_vld_d;
            win_last_q    <= win_last_d;
            prod_q        <= prod_d;
            s1_vld_q      <= s1_vld_d;
            s1_last_q     <= s1_last_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
        end
    end
endmodule

// File: tb/tb_conv_pu_stream.sv
// Directed bench for conv_pu_stream (K=3, 5x5): frame table plus stall, clear and weight-phase sequences.
module tb_conv_pu_stream;
    logic        clk = 1'b0;
    logic        rst, clear, wgt_valid, start, relu_en, stride_sel, in_valid, out_ready;
    logic [15:0] wgt_data;
    logic [31:0] bias;
    logic [7:0]  in_data;
    logic        wgt_ready, in_ready, out_valid, out_last, busy, done;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    conv_pu_stream dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wgt_valid(wgt_valid), .wgt_data(wgt_data), .wgt_ready(wgt_ready),
        .start(start), .bias(bias), .relu_en(relu_en), .stride_sel(stride_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    typedef struct {
        string name;
        int    wgt;
        int    stride;
        int    relu;
        int    bias;
        int    n;
        int    exp [9];
    } vec_t;

    vec_t tbl [4];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc13 = 0;
    int   got_q [$];
    bit   last_q [$];
    int   rises_q [$];
    int   done_cnt = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back($signed(out_data));
            last_q.push_back(out_last);
        end
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && prev_vld !== 1'b1) rises_q.push_back(cyc);
        prev_vld = out_valid;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_wgts(input int v, input bit start_on_last);
        for (int i = 0; i < 9; i++) begin
            wgt_valid = 1'b1;
            wgt_data  = 16'(v);
            start     = (i == 8) && start_on_last;
            tick();
        end
        wgt_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic run_frame(input int ti, input bit stall_first, input bit noise, input int npix);
        vec_t v;
        int   base, dbase, rbase, g;
        v     = tbl[ti];
        base  = got_q.size();
        dbase = done_cnt;
        rbase = rises_q.size();
        bias       = 32'(v.bias);
        relu_en    = v.relu[0];
        stride_sel = v.stride[0];
        out_ready  = !stall_first;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        fork
            begin
                for (int p = 1; p <= npix; p++) begin
                    int guard;
                    bit acc;
                    guard     = 0;
                    acc       = 1'b0;
                    in_valid  = 1'b1;
                    in_data   = 8'(p);
                    wgt_valid = noise;
                    wgt_data  = '0;
                    while (!acc && guard < 200) begin
                        @(negedge clk);
                        if (noise && p == 5) chk("wgt_ready_in_run", wgt_ready, 0);
                        if (in_ready) begin
                            acc = 1'b1;
                            if (p == 13) acc13 = cyc;
                        end
                        tick();
                        guard++;
                    end
                    if (!acc) chk("in_ready_timeout", 0, 1);
                end
                in_valid  = 1'b0;
                wgt_valid = 1'b0;
            end
            begin
                if (stall_first) begin
                    int sg;
                    sg = 0;
                    @(negedge clk);
                    while (!out_valid && sg < 300) begin
                        @(negedge clk);
                        sg++;
                    end
                    chk("stall_vld_seen", out_valid, 1);
                    for (int i = 0; i < 4; i++) begin
                        if (i > 0) @(negedge clk);
                        chk("stall_in_ready", in_ready, 0);
                        chk("stall_hold_data", $signed(out_data), 63);
                        chk("stall_hold_vld", out_valid, 1);
                    end
                    tick();
                    out_ready = 1'b1;
                end
            end
        join

        if (npix < 25) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            @(negedge clk);
            chk("clear_busy", busy, 0);
            repeat (20) @(negedge clk);
            chk("clear_no_out", got_q.size() - base, 0);
            chk("clear_no_done", done_cnt - dbase, 0);
            return;
        end

        g = 0;
        while (done_cnt == dbase && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        chk({v.name, "_count"}, got_q.size() - base, v.n);
        for (int i = 0; i < v.n; i++) begin
            if (base + i < got_q.size()) begin
                chk({v.name, "_data"}, got_q[base+i], v.exp[i]);
                chk({v.name, "_last"}, last_q[base+i], (i == v.n - 1) ? 1 : 0);
            end
        end
        chk({v.name, "_done_once"}, done_cnt - dbase, 1);
        chk({v.name, "_idle"}, busy, 0);
        if (noise) begin
            if (rises_q.size() > rbase) chk("first_latency", rises_q[rbase] - acc13, 3);
            else chk("first_latency_seen", 0, 1);
        end
    endtask

    initial begin
        tbl[0] = '{"s1",      1, 0, 0, 0,  9, '{63, 72, 81, 108, 117, 126, 153, 162, 171}};
        tbl[1] = '{"s2",      1, 1, 0, 0,  4, '{63, 81, 153, 171, 0, 0, 0, 0, 0}};
        tbl[2] = '{"neg",    -1, 0, 0, 10, 9, '{-53, -62, -71, -98, -107, -116, -143, -152, -161}};
        tbl[3] = '{"relu",   -1, 0, 1, 10, 9, '{0, 0, 0, 0, 0, 0, 0, 0, 0}};

        rst = 1'b1; clear = 1'b0; wgt_valid = 1'b0; wgt_data = '0; start = 1'b0;
        bias = '0; relu_en = 1'b0; stride_sel = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wgt_ready", wgt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_no_wgts", busy, 0);

        load_wgts(1, 1'b1);
        @(negedge clk);
        chk("start_with_last_wgt", busy, 0);

        run_frame(0, 1'b0, 1'b1, 25);
        for (int t = 1; t < 4; t++) begin
            if (tbl[t].wgt != tbl[t-1].wgt) load_wgts(tbl[t].wgt, 1'b0);
            run_frame(t, 1'b0, 1'b0, 25);
        end

        load_wgts(1, 1'b0);
        run_frame(0, 1'b1, 1'b0, 25);
        run_frame(0, 1'b0, 1'b0, 10);
        run_frame(0, 1'b0, 1'b0, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
